// File: rtl/io_map_pkg.sv
// Shared address map, status bit layout and button state encoding for the
// board-input peripheral.
package io_map_pkg;

    localparam int DEFAULT_DATA_ADDR   = 65;
    localparam int DEFAULT_STATUS_ADDR = 66;

    localparam int VALID_BIT   = 0;
    localparam int OVERRUN_BIT = 1;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } btn_state_t;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer plus debounce FSM for an active-low push-button.
// The press pulse is asserted in the same cycle that commits the PRESSED state.
module debounce_sync
    import io_map_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q;
    btn_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pressed_raw;
    logic             differs;
    logic             done;

    // Synchronizer resets to the released level so a held button is seen as a new press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_n};
        end
    end

    assign pressed_raw = ~sync_q[1];
    assign differs     = (pressed_raw != (state_q == PRESSED));
    assign done        = differs && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else if (done) begin
            state_q <= (state_q == PRESSED) ? RELEASED : PRESSED;
            cnt_q   <= '0;
        end else if (differs) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    assign level = (state_q == PRESSED);
    assign press = done && (state_q == RELEASED);

endmodule

// File: rtl/switch_input_port.sv
// Memory-mapped slide-switch / push-button input port with combinational
// read decode and a sticky valid/overrun status word.
module switch_input_port
    import io_map_pkg::*;
#(
    parameter int REG_WIDTH       = 32,
    parameter int ADDR_WIDTH      = 8,
    parameter int SW_WIDTH        = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DATA_ADDR       = DEFAULT_DATA_ADDR,
    parameter int STATUS_ADDR     = DEFAULT_STATUS_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SW_WIDTH-1:0]   sw_in,
    input  logic                  btn_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [REG_WIDTH-1:0]  rd_data,
    output logic                  hit,
    output logic                  valid_led
);

    logic [SW_WIDTH-1:0]  sw_meta_q, sw_sync_q;
    logic [REG_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 btn_level_unused;
    logic                 press;
    logic                 is_data, is_status, data_rd;
    logic [REG_WIDTH-1:0] status_word;

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_n),
        .level (btn_level_unused),
        .press (press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign is_data   = (rd_addr == ADDR_WIDTH'(DATA_ADDR));
    assign is_status = (rd_addr == ADDR_WIDTH'(STATUS_ADDR));
    assign hit       = is_data || is_status;
    assign data_rd   = rd_en && is_data;

    // A capture wins over a same-edge data read; the read consumed the old value,
    // so the new capture starts clean with no overrun.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (press) begin
            data_d                = '0;
            data_d[SW_WIDTH-1:0]  = sw_sync_q;
            valid_d               = 1'b1;
            overrun_d             = valid_q && !data_rd;
        end else if (data_rd) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        status_word              = '0;
        status_word[VALID_BIT]   = valid_q;
        status_word[OVERRUN_BIT] = overrun_q;
    end

    always_comb begin
        if (is_data) begin
            rd_data = data_q;
        end else if (is_status) begin
            rd_data = status_word;
        end else begin
            rd_data = '0;
        end
    end

    assign valid_led = valid_q;

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port with a short debounce window; captured
// switch values are queued when a press is driven and checked on data reads.
module tb_switch_input_port;

    localparam int W      = 32;
    localparam int AW     = 8;
    localparam int SWW    = 10;
    localparam int DEB    = 4;
    localparam logic [AW-1:0] A_DATA   = 8'd65;
    localparam logic [AW-1:0] A_STATUS = 8'd66;

    logic           clk = 1'b0;
    logic           rst;
    logic [SWW-1:0] sw_in;
    logic           btn_n;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [W-1:0]   rd_data;
    logic           hit;
    logic           valid_led;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mdl_data;
    int n_cmp = 0;
    int n_err = 0;

    switch_input_port #(
        .REG_WIDTH      (W),
        .ADDR_WIDTH     (AW),
        .SW_WIDTH       (SWW),
        .DEBOUNCE_CYCLES(DEB),
        .DATA_ADDR      (65),
        .STATUS_ADDR    (66)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_in     (sw_in),
        .btn_n     (btn_n),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .hit       (hit),
        .valid_led (valid_led)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [AW-1:0] addr, input string tag, input logic [W-1:0] exp);
        rd_en   = 1'b0;
        rd_addr = addr;
        #1;
        check(tag, rd_data, exp);
    endtask

    // Consuming data read: the newest queued capture is the one that must be visible.
    task automatic data_read(input string tag);
        logic [W-1:0] exp;
        exp = mdl_data;
        if (exp_q.size() > 0) exp = exp_q[$];
        exp_q.delete();
        mdl_data = exp;
        rd_en   = 1'b1;
        rd_addr = A_DATA;
        #1;
        check(tag, rd_data, exp);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic press_button(input logic [SWW-1:0] v);
        sw_in = v;
        btn_n = 1'b0;
        exp_q.push_back(W'(v));
        repeat (8) tick();
        btn_n = 1'b1;
        repeat (8) tick();
    endtask

    initial begin
        rst      = 1'b1;
        sw_in    = '0;
        btn_n    = 1'b1;
        rd_en    = 1'b0;
        rd_addr  = '0;
        mdl_data = '0;
        repeat (3) tick();

        // Reset state
        #1;
        check("rst_hit_addr0", W'(hit), W'(0));
        check("rst_valid_led", W'(valid_led), W'(0));
        peek(8'd0, "rst_rd_addr0", 32'h0);
        peek(A_STATUS, "rst_status", 32'h0);
        peek(A_DATA, "rst_data", 32'h0);
        check("hit_data_addr", W'(hit), W'(1));
        rd_addr = 8'd67;
        #1;
        check("hit_addr67", W'(hit), W'(0));
        rst = 1'b0;
        tick();

        // Single press: commit lands on edge 5 counting from the first edge after btn falls
        sw_in = 10'h2A5;
        btn_n = 1'b0;
        exp_q.push_back(32'h2A5);
        for (int i = 0; i <= 6; i++) begin
            tick();
            check($sformatf("press_latency_e%0d", i), W'(valid_led), W'(i >= 5));
        end
        repeat (3) tick();
        btn_n = 1'b1;
        repeat (8) tick();
        check("release_keeps_valid", W'(valid_led), W'(1));
        peek(A_STATUS, "status_after_press", 32'h1);
        peek(8'd0, "other_addr_zero", 32'h0);
        data_read("data_2a5");
        peek(A_STATUS, "status_after_read", 32'h0);

        // Bounce never completes the count
        sw_in = 10'h155;
        btn_n = 1'b0; repeat (2) tick();
        btn_n = 1'b1; tick();
        btn_n = 1'b0; repeat (3) tick();
        btn_n = 1'b1; repeat (10) tick();
        peek(A_STATUS, "bounce_status", 32'h0);
        peek(A_DATA, "bounce_data", mdl_data);

        // Two presses without a read in between -> overrun
        press_button(10'h011);
        press_button(10'h3FF);
        peek(A_STATUS, "overrun_status", 32'h3);
        data_read("data_3ff");
        peek(A_STATUS, "status_after_overrun_read", 32'h0);

        // Data read on the commit edge
        press_button(10'h011);
        data_read("data_011");
        sw_in = 10'h055;
        btn_n = 1'b0;
        repeat (5) tick();
        rd_en   = 1'b1;
        rd_addr = A_DATA;
        #1;
        check("same_edge_old_data", rd_data, mdl_data);
        tick();
        rd_en = 1'b0;
        exp_q.push_back(32'h055);
        peek(A_STATUS, "same_edge_status", 32'h1);
        data_read("same_edge_new_data");
        btn_n = 1'b1;
        repeat (8) tick();

        // Reset mid-debounce with the button held
        sw_in = 10'h1C3;
        btn_n = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        exp_q.delete();
        mdl_data = '0;
        #1;
        peek(A_STATUS, "mid_rst_status", 32'h0);
        peek(A_DATA, "mid_rst_data", 32'h0);
        repeat (3) begin
            tick();
            check("in_rst_valid_led", W'(valid_led), W'(0));
        end
        rst = 1'b0;
        exp_q.push_back(32'h1C3);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("post_rst_e%0d", i), W'(valid_led), W'(i >= 6));
        end
        data_read("post_rst_data");
        peek(A_STATUS, "post_rst_status", 32'h0);
        btn_n = 1'b1;
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/switch_input_port.md
# switch_input_port

Memory-mapped board-input peripheral for the FPGA build of the RISC-V single-cycle processor. It synchronizes the slide switches and one push-button, debounces the button, and on each confirmed press captures the switch value into a data register with a sticky valid flag. The processor polls a status word and reads the captured value through two load-only addresses. Reads are combinational so that a `lw` completes in its own cycle.

## Interface
Parameters:
- REG_WIDTH, 32, processor data width.
- ADDR_WIDTH, 8, width of the word address driven by the processor.
- SW_WIDTH, 10, number of slide switches; must be ≤ REG_WIDTH.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a button transition; must be ≥ 2.
- DATA_ADDR, 65, word address of the data register.
- STATUS_ADDR, 66, word address of the status register.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- sw_in  in  SW_WIDTH  raw slide switches, asynchronous.
- btn_n  in  1  raw push-button, active-low, asynchronous, bouncy.
- rd_en  in  1  processor load strobe.
- rd_addr  in  ADDR_WIDTH  processor word address.
- rd_data  out  REG_WIDTH  read data, combinational.
- hit  out  1  high when rd_addr equals DATA_ADDR or STATUS_ADDR; combinational, independent of rd_en.
- valid_led  out  1  copy of the valid flag.

## Operation
- Synchronizers: two flops on sw_in and two flops on btn_n.
  - Reset values: switch flops 0; button flops 1 (released).
- Debounce FSM has states RELEASED and PRESSED, plus a counter `cnt`.
  - If the synced button level differs from the committed state: `cnt` increments.
  - If the level matches the committed state: `cnt` clears to 0.
  - When the level still differs and `cnt == DEBOUNCE_CYCLES-1`, the FSM moves to the other state and `cnt` clears.
  - A RELEASED→PRESSED transition raises a one-cycle `press` pulse. PRESSED→RELEASED raises no pulse.
- On `press`:
  - Data register ← synced switches, zero-extended to REG_WIDTH.
  - If valid is already 1, overrun ← 1.
  - valid ← 1.
- Status word: bit0 = valid, bit1 = overrun, all other bits 0.
- rd_data:
  - rd_addr == DATA_ADDR: data register.
  - rd_addr == STATUS_ADDR: status word.
  - Any other address: 0.
- Side effects occur only at a clock edge with rd_en=1.
  - Data read clears both valid and overrun.
  - Status read has no side effect.
- Same edge carries a data read and `press`:
  - rd_data in that cycle returns the old value.
  - After the edge: new value captured, valid=1, overrun=0.
- Reset (any time, including mid-debounce): FSM RELEASED, `cnt`=0, data=0, valid=0, overrun=0, rd_data reflects the cleared registers.
- A button held down through reset registers as a new press once debounced after reset release.

## Timing
- Read data is combinational. Side effects land at the edge that ends the read cycle.
- Press latency:
  - btn_n falls before edge k.
  - The synced level is first low after edge k+1.
  - The commit happens at edge k+1+DEBOUNCE_CYCLES.
  - valid and valid_led are high after that edge.
- Release latency is the same. A release never changes valid, data or overrun.
- Any return to the committed level before the count completes restarts the count from 0.
- Switch changes made less than 2 cycles before the commit edge are not guaranteed to be captured.

## Structure
- Package `io_map_pkg` holds:
  - DATA_ADDR and STATUS_ADDR defaults.
  - Status bit indices VALID_BIT=0 and OVERRUN_BIT=1.
  - Enum `btn_state_t` {RELEASED, PRESSED}.
- Sub-module `debounce_sync` holds the button synchronizer, debounce FSM and counter, and outputs `level` and `press`. The top level holds the switch synchronizer, data/valid/overrun registers and read decode.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset assertion → status=0x0, data=0x0, hit=0 at address 0, valid_led=0.
- sw_in=0x2A5; btn_n low before edge 0 and held 10 cycles → valid_led high after edge 5. Status read=0x1; data read=0x000002A5; status=0x0 after the read edge.
- Bounce: btn_n pattern low 2 cycles, high 1, low 3, high → no commit, status stays 0x0, data unchanged.
- Press with sw=0x011, release, press with sw=0x3FF, no reads in between → status=0x3, data=0x3FF. Data read → status=0x0.
- Data read on the same edge as a commit of sw=0x055, with old data 0x011 → rd_data=0x011 in that cycle, then status=0x1 and data=0x055.
- Reset asserted at debounce count 2 with btn_n held low → no capture during reset. After release, valid rises 5 edges after the first post-reset edge.
